tx_byte_ctrl: RTL and testbench

- Transmit-side controller that frames bytes for the serial TX path.
- Pulls bytes from a first-word-fall-through TX FIFO and serializes each one LSB-first as: start bit, 8 data bits, stop bit.
- Drives the enable of the downstream 9-count bit timer (timer2_tx) and consumes its bits8 rollover flag as the byte-end marker.
- Sends a packet of byte_count bytes per tx_start, then reports done or error.

---
 rtl/tx_pkg.sv | 23 ++
 rtl/tx_shift_reg.sv | 35 +++
 rtl/tx_byte_ctrl.sv | 151 +++++++++++++++
 tb/tb_tx_byte_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared types and constants for the transmit byte controller.
// Contents:
//   tx_state_t  - controller FSM states
//   START_BIT / STOP_BIT / IDLE_LEVEL - serial line levels
//   DATA_BITS   - data bits per frame
//   LAST_IDX    - bit_idx value of the stop-bit cycle
package tx_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SEND = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } tx_state_t;

  localparam logic       START_BIT  = 1'b0;
  localparam logic       STOP_BIT   = 1'b1;
  localparam logic       IDLE_LEVEL = 1'b1;
  localparam int         DATA_BITS  = 8;
  localparam logic [3:0] LAST_IDX   = 4'd8;

endpackage

// File: rtl/tx_shift_reg.sv
// 8-bit parallel-in serial-out shift register for the TX frame data.
// Ports:
//   clk      - system clock, rising edge
//   n_rst    - asynchronous active-low reset (register resets to all ones)
//   load     - capture din (takes priority over shift_en)
//   shift_en - shift right by one, filling with the idle level
//   din      - parallel data
//   sout     - serial output, always bit 0 of the register
module tx_shift_reg
  import tx_pkg::*;
(
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 load,
  input  logic                 shift_en,
  input  logic [DATA_BITS-1:0] din,
  output logic                 sout
);

  logic [DATA_BITS-1:0] shreg;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shreg <= '1;
    end else if (load) begin
      shreg <= din;
    end else if (shift_en) begin
      // Fill with the idle level so an over-shifted register reads as line-idle.
      shreg <= {IDLE_LEVEL, shreg[DATA_BITS-1:1]};
    end
  end

  assign sout = shreg[0];

endmodule

// File: rtl/tx_byte_ctrl.sv
// Transmit byte controller: frames bytes from a first-word-fall-through TX
// FIFO as start bit, 8 data bits (LSB first), stop bit, for a packet of
// byte_count bytes per tx_start. The downstream 9-count bit timer is enabled
// during data/stop bits and its bits8 rollover marks the stop-bit cycle.
// Ports:
//   clk, n_rst          - clock (rising edge), async active-low reset
//   tx_start            - packet request, sampled in IDLE only
//   byte_count          - packet length, sampled with tx_start (0 = ignored)
//   fifo_rdata          - FIFO head byte, valid while fifo_empty=0
//   fifo_empty          - FIFO empty flag
//   fifo_pop            - one-cycle pop of the FIFO head
//   bits8               - bit-timer rollover flag
//   enable_timer_bits8  - bit-timer enable (low clears the timer)
//   serial_out          - serial line, idle high
//   tx_active           - high in LOAD and SEND
//   tx_done / tx_error  - one-cycle completion / failure pulses
//   state_dbg           - current FSM state, for observation only
//
// FIFO handshake: the FIFO presents its head on fifo_rdata whenever
// fifo_empty=0 (the "valid" side). The controller consumes the head by
// raising fifo_pop for exactly one cycle (LOAD), and captures fifo_rdata at
// the end of that same cycle; the FIFO advances its head on that edge.
// fifo_pop is only raised when fifo_empty was seen low before entering LOAD.
//
// All outputs are decoded from state and registers; no input reaches an
// output combinationally.
module tx_byte_ctrl
  import tx_pkg::*;
#(
  parameter int CNT_W = 7
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 tx_start,
  input  logic [CNT_W-1:0]     byte_count,
  input  logic [DATA_BITS-1:0] fifo_rdata,
  input  logic                 fifo_empty,
  output logic                 fifo_pop,
  input  logic                 bits8,
  output logic                 enable_timer_bits8,
  output logic                 serial_out,
  output logic                 tx_active,
  output logic                 tx_done,
  output logic                 tx_error,
  output tx_state_t            state_dbg
);

  tx_state_t        state, state_nxt;
  logic [CNT_W-1:0] bytes_left, bytes_left_nxt;
  logic [3:0]       bit_idx, bit_idx_nxt;
  logic             sh_load, sh_shift, sh_out;
  logic             stop_cycle;

  assign stop_cycle = (bit_idx == LAST_IDX);
  assign state_dbg  = state;

  tx_shift_reg u_shift (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (sh_load),
    .shift_en (sh_shift),
    .din      (fifo_rdata),
    .sout     (sh_out)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      bytes_left <= '0;
      bit_idx    <= '0;
    end else begin
      state      <= state_nxt;
      bytes_left <= bytes_left_nxt;
      bit_idx    <= bit_idx_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    bytes_left_nxt = bytes_left;
    bit_idx_nxt    = bit_idx;
    sh_load        = 1'b0;
    sh_shift       = 1'b0;
    case (state)
      IDLE: begin
        if (tx_start && (byte_count != '0)) begin
          if (fifo_empty) begin
            state_nxt = ERR;
          end else begin
            bytes_left_nxt = byte_count;
            state_nxt      = LOAD;
          end
        end
      end
      LOAD: begin
        sh_load     = 1'b1;
        bit_idx_nxt = '0;
        state_nxt   = SEND;
      end
      SEND: begin
        sh_shift    = 1'b1;
        bit_idx_nxt = bit_idx + 4'd1;
        if (stop_cycle) begin
          // The timer must roll over exactly on the stop-bit cycle.
          if (!bits8) begin
            state_nxt = ERR;
          end else begin
            bytes_left_nxt = bytes_left - CNT_W'(1);
            if (bytes_left == CNT_W'(1)) begin
              state_nxt = DONE;
            end else if (fifo_empty) begin
              state_nxt = ERR;
            end else begin
              state_nxt = LOAD;
            end
          end
        end else if (bits8) begin
          state_nxt = ERR;
        end
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    serial_out         = IDLE_LEVEL;
    enable_timer_bits8 = 1'b0;
    fifo_pop           = 1'b0;
    tx_active          = 1'b0;
    tx_done            = 1'b0;
    tx_error           = 1'b0;
    case (state)
      LOAD: begin
        serial_out = START_BIT;
        fifo_pop   = 1'b1;
        tx_active  = 1'b1;
      end
      SEND: begin
        enable_timer_bits8 = 1'b1;
        tx_active          = 1'b1;
        serial_out         = stop_cycle ? STOP_BIT : sh_out;
      end
      DONE:    tx_done  = 1'b1;
      ERR:     tx_error = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tx_byte_ctrl.sv
// Bench for tx_byte_ctrl: a queue-based FIFO model, a 9-count bit-timer
// model, a frame-level reference model producing a per-cycle expected output
// queue, a table of packet scenarios, hand-written corner sequences and
// randomized packets.
module tb_tx_byte_ctrl;

  localparam int CNT_W = 7;

  // Packed output vector: {serial, enable, pop, active, done, error}
  localparam logic [5:0] V_IDLE = 6'b100000;
  localparam logic [5:0] V_LOAD = 6'b001100;
  localparam logic [5:0] V_STOP = 6'b110100;
  localparam logic [5:0] V_DONE = 6'b100010;
  localparam logic [5:0] V_ERR  = 6'b100001;

  logic             clk = 1'b0;
  logic             n_rst = 1'b1;
  logic             tx_start = 1'b0;
  logic [CNT_W-1:0] byte_count = '0;
  logic [7:0]       fifo_rdata = 8'h00;
  logic             fifo_empty = 1'b1;
  logic             bits8 = 1'b0;
  logic             fifo_pop, enable_timer_bits8, serial_out;
  logic             tx_active, tx_done, tx_error;
  tx_pkg::tx_state_t state_dbg;

  always #5 clk = ~clk;

  tx_byte_ctrl #(.CNT_W(CNT_W)) dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .tx_start           (tx_start),
    .byte_count         (byte_count),
    .fifo_rdata         (fifo_rdata),
    .fifo_empty         (fifo_empty),
    .fifo_pop           (fifo_pop),
    .bits8              (bits8),
    .enable_timer_bits8 (enable_timer_bits8),
    .serial_out         (serial_out),
    .tx_active          (tx_active),
    .tx_done            (tx_done),
    .tx_error           (tx_error),
    .state_dbg          (state_dbg)
  );

  logic [7:0] fifo_q[$];
  logic [5:0] exp_q[$];
  int total = 0;
  int bad = 0;
  logic pop_pending = 1'b0;
  logic en_prev = 1'b0;
  logic force_b8 = 1'b0;
  int tcnt = 0;
  int n_done, n_err, n_pop, n_act;

  typedef struct {
    int         cnt;
    int         nfill;
    logic [7:0] b0, b1, b2;
    int         done, err, pops, act;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [5:0] outs();
    return {serial_out, enable_timer_bits8, fifo_pop, tx_active, tx_done, tx_error};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fifo_refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_rdata = fifo_empty ? 8'h00 : fifo_q[0];
  endtask

  // Advance one clock; update the FIFO and timer models for the new cycle,
  // then sample the DUT outputs of that cycle.
  task automatic step();
    @(posedge clk);
    #1;
    if (pop_pending && fifo_q.size() > 0) void'(fifo_q.pop_front());
    fifo_refresh();
    if (!en_prev || tcnt == 8) tcnt = 0;
    else tcnt++;
    bits8       = force_b8 | (tcnt == 8);
    pop_pending = fifo_pop;
    en_prev     = enable_timer_bits8;
    n_done += int'(tx_done);
    n_err  += int'(tx_error);
    n_pop  += int'(fifo_pop);
    n_act  += int'(tx_active);
  endtask

  // Frame-level reference: what the line looks like from N+1 onward for a
  // packet of cnt bytes given the FIFO contents at the request.
  task automatic build_exp(input int cnt);
    int avail;
    logic [7:0] b;
    avail = fifo_q.size();
    exp_q.delete();
    if (cnt != 0) begin
      if (avail == 0) begin
        exp_q.push_back(V_ERR);
      end else begin
        for (int i = 0; i < cnt; i++) begin
          b = fifo_q[i];
          exp_q.push_back(V_LOAD);
          for (int j = 0; j < 8; j++) exp_q.push_back({b[j], 5'b10100});
          exp_q.push_back(V_STOP);
          if (i == cnt - 1) begin
            exp_q.push_back(V_DONE);
            break;
          end else if (i + 1 >= avail) begin
            exp_q.push_back(V_ERR);
            break;
          end
        end
      end
    end
    exp_q.push_back(V_IDLE);
  endtask

  task automatic run_packet(input int cnt, input bit noise);
    int k;
    build_exp(cnt);
    k = exp_q.size();
    n_done = 0; n_err = 0; n_pop = 0; n_act = 0;
    byte_count = CNT_W'(cnt);
    tx_start   = 1'b1;
    step();
    tx_start = 1'b0;
    for (int i = 0; i < k; i++) begin
      check($sformatf("cyc%0d_of_len%0d", i, cnt), 32'(outs()), 32'(exp_q[i]));
      if (noise && i < k - 1) begin
        // Requests while busy or in DONE/ERR must be ignored.
        tx_start   = 1'($urandom_range(0, 1));
        byte_count = CNT_W'($urandom_range(0, 5));
      end else begin
        tx_start = 1'b0;
      end
      if (i < k - 1) step();
    end
    tx_start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] ser;
    int pops;

    vecs[0] = '{cnt: 1,   nfill: 1,   b0: 8'hA5, b1: 8'h00, b2: 8'h00, done: 1, err: 0, pops: 1,   act: 10};
    vecs[1] = '{cnt: 3,   nfill: 3,   b0: 8'h00, b1: 8'hFF, b2: 8'h3C, done: 1, err: 0, pops: 3,   act: 30};
    vecs[2] = '{cnt: 2,   nfill: 1,   b0: 8'h5A, b1: 8'h00, b2: 8'h00, done: 0, err: 1, pops: 1,   act: 10};
    vecs[3] = '{cnt: 4,   nfill: 0,   b0: 8'h00, b1: 8'h00, b2: 8'h00, done: 0, err: 1, pops: 0,   act: 0};
    vecs[4] = '{cnt: 0,   nfill: 1,   b0: 8'h77, b1: 8'h00, b2: 8'h00, done: 0, err: 0, pops: 0,   act: 0};
    vecs[5] = '{cnt: 2,   nfill: 3,   b0: 8'h11, b1: 8'h22, b2: 8'h33, done: 1, err: 0, pops: 2,   act: 20};
    vecs[6] = '{cnt: 127, nfill: 127, b0: 8'h81, b1: 8'h7E, b2: 8'hC3, done: 1, err: 0, pops: 127, act: 1270};

    // Reset: outputs take reset values asynchronously.
    #2 n_rst = 1'b0;
    #1 check("reset_async_outs", 32'(outs()), 32'(V_IDLE));
    step();
    step();
    check("reset_held_outs", 32'(outs()), 32'(V_IDLE));
    n_rst = 1'b1;
    step();
    check("post_reset_outs", 32'(outs()), 32'(V_IDLE));

    // Single byte A5, explicit waveform against hand-derived constants.
    fifo_q.delete();
    fifo_q.push_back(8'hA5);
    fifo_refresh();
    byte_count = CNT_W'(1);
    tx_start   = 1'b1;
    step();
    tx_start = 1'b0;
    ser  = '0;
    pops = 0;
    for (int i = 0; i < 10; i++) begin
      ser[i] = serial_out;
      pops  += int'(fifo_pop);
      if (i == 0) check("a5_pop_at_n1", 32'(fifo_pop), 32'd1);
      if (i < 9) step();
    end
    check("a5_serial", 32'(ser), 32'(10'b1101001010));
    check("a5_pop_count", 32'(pops), 32'd1);
    step();
    check("a5_done_n11", 32'({tx_done, tx_error}), 32'b10);
    step();
    check("a5_idle_after", 32'(outs()), 32'(V_IDLE));

    // Table of packet scenarios.
    for (int v = 0; v < 7; v++) begin
      fifo_q.delete();
      for (int j = 0; j < vecs[v].nfill; j++) begin
        if (j == 0)      fifo_q.push_back(vecs[v].b0);
        else if (j == 1) fifo_q.push_back(vecs[v].b1);
        else if (j == 2) fifo_q.push_back(vecs[v].b2);
        else             fifo_q.push_back(8'(j));
      end
      fifo_refresh();
      run_packet(vecs[v].cnt, 1'b0);
      check($sformatf("vec%0d_done", v), 32'(n_done), 32'(vecs[v].done));
      check($sformatf("vec%0d_err", v), 32'(n_err), 32'(vecs[v].err));
      check($sformatf("vec%0d_pops", v), 32'(n_pop), 32'(vecs[v].pops));
      check($sformatf("vec%0d_active", v), 32'(n_act), 32'(vecs[v].act));
      fifo_q.delete();
      fifo_refresh();
    end

    // Timer mismatch: bits8 raised at bit_idx=5 (cycle N+7).
    fifo_q.push_back(8'hC3);
    fifo_refresh();
    byte_count = CNT_W'(1);
    tx_start   = 1'b1;
    step();
    tx_start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    force_b8 = 1'b1;
    step();
    force_b8 = 1'b0;
    step();
    check("mismatch_err", 32'(outs()), 32'(V_ERR));
    step();
    check("mismatch_idle", 32'(outs()), 32'(V_IDLE));

    // Reset in the middle of a frame (bit_idx=4, cycle N+6).
    fifo_q.delete();
    fifo_q.push_back(8'h96);
    fifo_q.push_back(8'h5B);
    fifo_refresh();
    byte_count = CNT_W'(2);
    tx_start   = 1'b1;
    step();
    tx_start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("midframe_enabled", 32'(enable_timer_bits8), 32'd1);
    #2 n_rst = 1'b0;
    #1 check("midframe_reset_async", 32'(outs()), 32'(V_IDLE));
    step();
    check("midframe_reset_held", 32'(outs()), 32'(V_IDLE));
    n_rst = 1'b1;
    step();
    run_packet(1, 1'b0);
    check("after_reset_done", 32'(n_done), 32'd1);

    // Randomized packets with requests injected while busy.
    for (int it = 0; it < 30; it++) begin
      int cnt;
      int fill;
      cnt  = $urandom_range(0, 5);
      fill = $urandom_range(0, cnt + 1);
      for (int j = 0; j < fill; j++) fifo_q.push_back(8'($urandom));
      fifo_refresh();
      run_packet(cnt, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
